// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared encodings for the 5-stage pipeline: write-back source, RegDst select
// and the architecturally special register numbers.
package ex_mem_pipe_reg_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_RA  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Register-file writes only count for real instructions that target a non-zero register.
    function automatic logic qual_regwrite(input logic regwrite, input logic valid,
                                           input logic wr_is_zero);
        return regwrite & valid & ~wr_is_zero;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_hazard_cmp.sv
// Qualified register-number equality used for EX/MEM forwarding detection.
module ex_mem_pipe_reg_hazard_cmp #(
    parameter int REG_AW = 5
) (
    input  logic              i_en,
    input  logic [REG_AW-1:0] i_dst,
    input  logic [REG_AW-1:0] i_src,
    output logic              o_hit
);

    assign o_hit = i_en & (i_dst == i_src);

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with write qualification, bubble insertion on
// flush or invalid EX, and the EX/MEM forwarding / load-use indicators.
module ex_mem_pipe_reg
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ex_Valid,
    input  logic [REG_AW-1:0] ex_WriteReg,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic [1:0]        ex_MemtoReg,
    input  logic [DATA_W-1:0] ex_ALUResult,
    input  logic [DATA_W-1:0] ex_StoreData,
    input  logic [DATA_W-1:0] ex_PCPlus4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              mem_Valid,
    output logic [REG_AW-1:0] mem_WriteReg,
    output logic              mem_RegWrite,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [1:0]        mem_MemtoReg,
    output logic [DATA_W-1:0] mem_ALUResult,
    output logic [DATA_W-1:0] mem_StoreData,
    output logic [DATA_W-1:0] mem_PCPlus4,
    output logic              FwdA_hit,
    output logic              FwdB_hit,
    output logic              LoadUse
);

    logic              r_valid;
    logic [REG_AW-1:0] r_wreg;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic [1:0]        r_memtoreg;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_store;
    logic [DATA_W-1:0] r_pc4;

    logic w_bubble;
    logic w_wr_zero;
    logic w_fwd_a;
    logic w_fwd_b;

    // An invalid EX slot is captured exactly like a flush so no stale field leaks downstream.
    assign w_bubble  = Flush | ~ex_Valid;
    assign w_wr_zero = (ex_WriteReg == REG_AW'(REG_ZERO));

    always_ff @(posedge CLK) begin
        if (Reset || (w_bubble && (Flush || !Stall))) begin
            r_valid    <= 1'b0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= '0;
            r_alu      <= '0;
            r_store    <= '0;
            r_pc4      <= '0;
        end else if (!Stall) begin
            r_valid    <= 1'b1;
            r_wreg     <= ex_WriteReg;
            r_regwrite <= qual_regwrite(ex_RegWrite, ex_Valid, w_wr_zero);
            r_memread  <= ex_MemRead;
            r_memwrite <= ex_MemWrite;
            r_memtoreg <= ex_MemtoReg;
            r_alu      <= ex_ALUResult;
            r_store    <= ex_StoreData;
            r_pc4      <= ex_PCPlus4;
        end
    end

    assign mem_Valid     = r_valid;
    assign mem_WriteReg  = r_wreg;
    assign mem_RegWrite  = r_regwrite;
    assign mem_MemRead   = r_memread;
    assign mem_MemWrite  = r_memwrite;
    assign mem_MemtoReg  = r_memtoreg;
    assign mem_ALUResult = r_alu;
    assign mem_StoreData = r_store;
    assign mem_PCPlus4   = r_pc4;

    ex_mem_pipe_reg_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs (
        .i_en  (r_regwrite),
        .i_dst (r_wreg),
        .i_src (id_rs),
        .o_hit (w_fwd_a)
    );

    ex_mem_pipe_reg_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rt (
        .i_en  (r_regwrite),
        .i_dst (r_wreg),
        .i_src (id_rt),
        .o_hit (w_fwd_b)
    );

    assign FwdA_hit = w_fwd_a;
    assign FwdB_hit = w_fwd_b;
    assign LoadUse  = r_memread & r_regwrite & (w_fwd_a | w_fwd_b);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table followed by randomized traffic vs. a reference model.
module tb_ex_mem_pipe_reg;

    logic        CLK = 1'b0;
    logic        Reset, Stall, Flush, ex_Valid;
    logic [4:0]  ex_WriteReg;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [1:0]  ex_MemtoReg;
    logic [31:0] ex_ALUResult, ex_StoreData, ex_PCPlus4;
    logic [4:0]  id_rs, id_rt;
    logic        mem_Valid;
    logic [4:0]  mem_WriteReg;
    logic        mem_RegWrite, mem_MemRead, mem_MemWrite;
    logic [1:0]  mem_MemtoReg;
    logic [31:0] mem_ALUResult, mem_StoreData, mem_PCPlus4;
    logic        FwdA_hit, FwdB_hit, LoadUse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ex_Valid(ex_Valid),
        .ex_WriteReg(ex_WriteReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_ALUResult(ex_ALUResult),
        .ex_StoreData(ex_StoreData), .ex_PCPlus4(ex_PCPlus4), .id_rs(id_rs), .id_rt(id_rt),
        .mem_Valid(mem_Valid), .mem_WriteReg(mem_WriteReg), .mem_RegWrite(mem_RegWrite),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_ALUResult(mem_ALUResult), .mem_StoreData(mem_StoreData), .mem_PCPlus4(mem_PCPlus4),
        .FwdA_hit(FwdA_hit), .FwdB_hit(FwdB_hit), .LoadUse(LoadUse)
    );

    typedef struct {
        logic rst, stall, flush, valid;
        logic [4:0] wr;
        logic rw, mr, mw;
        logic [1:0] mtr;
        logic [31:0] alu, sd, pc4;
        logic [4:0] rs, rt;
        logic e_valid;
        logic [4:0] e_wr;
        logic e_rw, e_mr, e_mw;
        logic [1:0] e_mtr;
        logic [31:0] e_alu, e_sd, e_pc4;
        logic e_fa, e_fb, e_lu;
    } vec_t;

    vec_t tab[12];

    // Reference model state
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [4:0]  m_wr;
    logic [1:0]  m_mtr;
    logic [31:0] m_alu, m_sd, m_pc4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic fl, input logic v,
                         input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                         input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt);
        Reset = rst; Stall = st; Flush = fl; ex_Valid = v;
        ex_WriteReg = wr; ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw;
        ex_MemtoReg = mtr; ex_ALUResult = alu; ex_StoreData = sd; ex_PCPlus4 = pc4;
        id_rs = rs; id_rt = rt;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [4:0] wr,
                             input logic rw, input logic mr, input logic mw, input logic [1:0] mtr,
                             input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                             input logic fa, input logic fb, input logic lu);
        chk({tag, ".valid"}, 32'(mem_Valid), 32'(v));
        chk({tag, ".wreg"},  32'(mem_WriteReg), 32'(wr));
        chk({tag, ".regwr"}, 32'(mem_RegWrite), 32'(rw));
        chk({tag, ".memrd"}, 32'(mem_MemRead), 32'(mr));
        chk({tag, ".memwr"}, 32'(mem_MemWrite), 32'(mw));
        chk({tag, ".mtr"},   32'(mem_MemtoReg), 32'(mtr));
        chk({tag, ".alu"},   mem_ALUResult, alu);
        chk({tag, ".sd"},    mem_StoreData, sd);
        chk({tag, ".pc4"},   mem_PCPlus4, pc4);
        chk({tag, ".fwdA"},  32'(FwdA_hit), 32'(fa));
        chk({tag, ".fwdB"},  32'(FwdB_hit), 32'(fb));
        chk({tag, ".ldu"},   32'(LoadUse), 32'(lu));
    endtask

    initial begin
        // rst st fl v  wr rw mr mw mtr  alu sd pc4  rs rt | valid wr rw mr mw mtr alu sd pc4 fa fb lu
        tab[0]  = '{1,1,0,1, 8,1,1,0,2'd1, 32'hDEAD,32'hBEEF,32'h4, 8,8,
                    0,0,0,0,0,2'd0, 0,0,0, 0,0,0};
        tab[1]  = '{0,0,0,1, 8,1,0,0,2'd0, 32'h1234,0,32'h10, 8,3,
                    1,8,1,0,0,2'd0, 32'h1234,0,32'h10, 1,0,0};
        tab[2]  = '{0,0,0,1, 0,1,0,0,2'd0, 32'h5,32'h6,32'h14, 0,0,
                    1,0,0,0,0,2'd0, 32'h5,32'h6,32'h14, 0,0,0};
        tab[3]  = '{0,0,0,1, 9,1,1,0,2'd1, 32'h100,0,32'h18, 1,9,
                    1,9,1,1,0,2'd1, 32'h100,0,32'h18, 0,1,1};
        tab[4]  = '{0,1,0,1, 4,1,0,0,2'd0, 32'h777,32'h1,32'h1C, 1,9,
                    1,9,1,1,0,2'd1, 32'h100,0,32'h18, 0,1,1};
        tab[5]  = '{0,1,0,1, 4,1,0,1,2'd2, 32'h888,32'h2,32'h20, 4,9,
                    1,9,1,1,0,2'd1, 32'h100,0,32'h18, 0,1,1};
        tab[6]  = '{0,0,0,1, 10,1,0,0,2'd0, 32'hAA,0,32'h24, 10,9,
                    1,10,1,0,0,2'd0, 32'hAA,0,32'h24, 1,0,0};
        tab[7]  = '{0,1,1,1, 0,0,0,1,2'd0, 32'h200,32'h77,32'h28, 10,10,
                    0,0,0,0,0,2'd0, 0,0,0, 0,0,0};
        tab[8]  = '{0,0,0,1, 31,1,0,0,2'd2, 0,0,32'h0040_0008, 31,2,
                    1,31,1,0,0,2'd2, 0,0,32'h0040_0008, 1,0,0};
        tab[9]  = '{0,0,0,0, 5,1,1,0,2'd1, 32'h33,32'h44,32'h30, 5,5,
                    0,0,0,0,0,2'd0, 0,0,0, 0,0,0};
        tab[10] = '{0,0,0,1, 3,0,0,1,2'd0, 32'h300,32'hCAFE,32'h34, 3,3,
                    1,3,0,0,1,2'd0, 32'h300,32'hCAFE,32'h34, 0,0,0};
        tab[11] = '{1,0,1,1, 7,1,1,0,2'd1, 32'h1,32'h2,32'h3, 7,7,
                    0,0,0,0,0,2'd0, 0,0,0, 0,0,0};

        drive(1,0,0,0, 0,0,0,0,2'd0, 0,0,0, 0,0);
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) begin
            drive(tab[i].rst, tab[i].stall, tab[i].flush, tab[i].valid, tab[i].wr,
                  tab[i].rw, tab[i].mr, tab[i].mw, tab[i].mtr, tab[i].alu, tab[i].sd,
                  tab[i].pc4, tab[i].rs, tab[i].rt);
            @(posedge CLK); #1;
            check_all($sformatf("vec%0d", i), tab[i].e_valid, tab[i].e_wr, tab[i].e_rw,
                      tab[i].e_mr, tab[i].e_mw, tab[i].e_mtr, tab[i].e_alu, tab[i].e_sd,
                      tab[i].e_pc4, tab[i].e_fa, tab[i].e_fb, tab[i].e_lu);
        end

        // Randomized traffic; the last table row was a reset, so the model starts empty.
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_wr = 0; m_mtr = 0;
        m_alu = 0; m_sd = 0; m_pc4 = 0;
        for (int c = 0; c < 300; c++) begin
            logic rst, st, fl, v, rw, mr, mw;
            logic [4:0] wr, rs, rt;
            logic [1:0] mtr;
            logic [31:0] alu, sd, pc4;
            logic efa, efb;
            rst = ($urandom_range(31) == 0);
            st  = ($urandom_range(3) == 0);
            fl  = ($urandom_range(7) == 0);
            v   = ($urandom_range(7) != 0);
            wr  = 5'($urandom_range(7));
            if ($urandom_range(15) == 0) wr = 5'd31;
            rw  = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
            mtr = 2'($urandom);
            alu = $urandom; sd = $urandom; pc4 = $urandom;
            rs  = 5'($urandom_range(7)); rt = 5'($urandom_range(7));
            if ($urandom_range(7) == 0) rs = 5'd31;
            drive(rst, st, fl, v, wr, rw, mr, mw, mtr, alu, sd, pc4, rs, rt);
            @(posedge CLK); #1;
            if (rst || fl || (!st && !v)) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_wr = 0; m_mtr = 0;
                m_alu = 0; m_sd = 0; m_pc4 = 0;
            end else if (!st) begin
                m_valid = 1; m_wr = wr; m_rw = rw && (wr != 0); m_mr = mr; m_mw = mw;
                m_mtr = mtr; m_alu = alu; m_sd = sd; m_pc4 = pc4;
            end
            efa = m_rw && (m_wr == rs);
            efb = m_rw && (m_wr == rt);
            check_all($sformatf("rnd%0d", c), m_valid, m_wr, m_rw, m_mr, m_mw, m_mtr,
                      m_alu, m_sd, m_pc4, efa, efb, m_mr && m_rw && (efa || efb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
EX→MEM pipeline register of the 5-stage pipeline. Sits directly downstream of the EX-stage destination-register select and the ALU. Latches the selected destination register (WriteReg), write-back and memory control, ALU result, store data and PC+4 each cycle. Also exports the EX/MEM-hazard comparisons used by the forwarding and load-use stall logic.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, PC)
REG_AW, 5, register-number width

Ports:
CLK  in  1  pipeline clock, all state updates on rising edge
Reset  in  1  synchronous, active-high; clears all state on the next rising edge
Stall  in  1  hold current contents (MEM stage blocked)
Flush  in  1  load a bubble (branch/jump redirect or exception)
ex_Valid  in  1  EX stage holds a real instruction
ex_WriteReg  in  REG_AW  destination from RegDst select (rt / rd / 31)
ex_RegWrite  in  1  instruction writes the register file
ex_MemRead  in  1  load
ex_MemWrite  in  1  store
ex_MemtoReg  in  2  WB source: 00 ALU, 01 memory, 10 PC+4 (jal)
ex_ALUResult  in  DATA_W  ALU output / effective address
ex_StoreData  in  DATA_W  forwarded rt value for stores
ex_PCPlus4  in  DATA_W  link value
id_rs, id_rt  in  REG_AW each  source registers of the instruction now in ID/EX
mem_Valid, mem_WriteReg, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_ALUResult, mem_StoreData, mem_PCPlus4  out  (widths as inputs)  registered copies
FwdA_hit  out  1  EX/MEM forwarding applies to id_rs
FwdB_hit  out  1  EX/MEM forwarding applies to id_rt
LoadUse  out  1  load in EX/MEM whose result is needed by id_rs/id_rt

Behaviour:
- Reset (synchronous, active-high): all mem_* outputs 0 on the next edge. mem_Valid=0, mem_WriteReg=0.
- Priority each edge: Reset > Flush > Stall > normal load.
- Flush: bubble. mem_Valid, mem_RegWrite, mem_MemRead and mem_MemWrite become 0. Data fields may load any value but are zeroed for determinism. Flush overrides a simultaneous Stall.
- Stall (no Flush): every register keeps its value.
- Normal load: capture all ex_* fields. Latency is 1 cycle.
- Write qualification on load:
  - mem_RegWrite = ex_RegWrite & ex_Valid & (ex_WriteReg != 0). Writes to $0 never propagate.
  - mem_MemRead = ex_MemRead & ex_Valid.
  - mem_MemWrite = ex_MemWrite & ex_Valid.
- ex_Valid=0 without Flush: captured as a bubble, same as Flush.
- Hazard outputs are combinational from registered state and the id_* inputs:
  - FwdA_hit = mem_RegWrite & (mem_WriteReg == id_rs).
  - FwdB_hit is the same comparison against id_rt.
  - Because mem_RegWrite is already qualified, neither hit can assert for $0.
- LoadUse = mem_MemRead & mem_RegWrite & (FwdA_hit | FwdB_hit). It remains asserted while Stall holds the load.
- jal: destination 31 and MemtoReg=10 pass through unchanged. Forwarding of 31 is normal.
- No hidden state beyond the output registers. No ready/valid back-pressure beyond Stall.

Decomposition:
- Shared header pipeline_defs.vh holds:
  - MemtoReg encodings (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10).
  - RegDst encodings.
  - REG_RA=5'd31 and REG_ZERO=5'd0.
- Optional sub-module hazard_cmp: one qualified equality comparator, instantiated twice for rs and rt. Everything else stays flat.

Test Plan:
- Reset with Stall=1 and live inputs → after 1 edge all outputs 0, FwdA_hit/FwdB_hit/LoadUse=0.
- ex_WriteReg=8, RegWrite=1, ALUResult=0x1234, MemtoReg=00, then id_rs=8 → next cycle mem_WriteReg=8, mem_ALUResult=0x1234, FwdA_hit=1, FwdB_hit=0.
- ex_WriteReg=0, RegWrite=1, id_rs=id_rt=0 → mem_RegWrite=0, both hits 0.
- Load (MemRead=1, WriteReg=9) with id_rt=9 → LoadUse=1. Hold Stall=1 for 2 cycles → contents and LoadUse stay fixed. Release → next ex_* captured.
- Stall=1 and Flush=1 together on a valid store (MemWrite=1) → mem_Valid=0, mem_MemWrite=0, no hit outputs.
- jal: WriteReg=31, MemtoReg=10, PCPlus4=0x0040_0008 → passed through. id_rs=31 → FwdA_hit=1.
